// File: rtl/lcd_write_sequencer_if.sv
// Command handshake between the host fabric and the LCD write sequencer.
//   cmd_valid  host -> seq  host has a byte to write
//   cmd_rs     host -> seq  0 = instruction, 1 = data
//   cmd_data   host -> seq  byte to write
//   cmd_ready  seq -> host  sequencer accepts a byte this cycle
// A transfer happens on a clock edge where cmd_valid && cmd_ready.
interface lcd_write_sequencer_if;
  logic       cmd_valid;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_rs,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_rs,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/lcd_write_sequencer.sv
// HD44780-compatible character LCD write sequencer.
// Runs the power-up initialisation autonomously, then writes single
// command/data bytes taken from the host handshake. The LCD is write-only:
// pacing is done purely with cycle timers, the busy flag is never read.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   cmd        command handshake (slave side): valid/rs/data in, ready out
//   init_done  power-up init complete (sticky until reset)
//   lcd_en     LCD enable strobe (registered)
//   lcd_rs     LCD register select
//   lcd_rw     LCD read/write, tied to write (0)
//   lcd_data   LCD data bus
//
// Every timing parameter is a cycle count and must be >= 1.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// PWR_WAIT  | waiting T_POWERUP after reset before the first init command
// SETUP     | rs/data driven, EN low (address/data setup)
// EN_HIGH   | EN strobe high
// HOLD      | EN low again, rs/data still held
// EXEC_WAIT | LCD executing; wait depends on init entry or command type
// IDLE      | init complete, cmd_ready high, waiting for a host byte
module lcd_write_sequencer #(
  parameter int unsigned T_POWERUP   = 750000,
  parameter int unsigned T_EN_SETUP  = 4,
  parameter int unsigned T_EN_HIGH   = 25,
  parameter int unsigned T_EN_HOLD   = 4,
  parameter int unsigned T_EXEC      = 2000,
  parameter int unsigned T_EXEC_LONG = 82000,
  parameter int unsigned T_INIT_GAP  = 205000
) (
  input  logic                  clk,
  input  logic                  reset,
  lcd_write_sequencer_if.slave  cmd,
  output logic                  init_done,
  output logic                  lcd_en,
  output logic                  lcd_rs,
  output logic                  lcd_rw,
  output logic [7:0]            lcd_data
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned T_MAX = max2(max2(max2(T_POWERUP, T_EN_SETUP),
                                            max2(T_EN_HIGH, T_EN_HOLD)),
                                       max2(max2(T_EXEC, T_EXEC_LONG), T_INIT_GAP));
  localparam int unsigned TW = $clog2(T_MAX + 1);

  // The timer is a down-counter loaded with (phase length - 1); the phase
  // ends in the cycle where it reads zero.
  localparam logic [TW-1:0] LD_POWERUP = TW'(T_POWERUP - 1);
  localparam logic [TW-1:0] LD_SETUP   = TW'(T_EN_SETUP - 1);
  localparam logic [TW-1:0] LD_HIGH    = TW'(T_EN_HIGH - 1);
  localparam logic [TW-1:0] LD_HOLD    = TW'(T_EN_HOLD - 1);
  localparam logic [TW-1:0] LD_EXEC    = TW'(T_EXEC - 1);
  localparam logic [TW-1:0] LD_LONG    = TW'(T_EXEC_LONG - 1);
  localparam logic [TW-1:0] LD_GAP     = TW'(T_INIT_GAP - 1);

  localparam logic [2:0] INIT_LAST = 3'd6;

  typedef enum logic [2:0] {
    PWR_WAIT  = 3'd0,
    SETUP     = 3'd1,
    EN_HIGH   = 3'd2,
    HOLD      = 3'd3,
    EXEC_WAIT = 3'd4,
    IDLE      = 3'd5
  } state_t;

  // Init ROM: function set x4 (8-bit, 2 lines), display on, clear, entry mode.
  function automatic logic [7:0] rom_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2, 3'd3: return 8'h38;
      3'd4:                   return 8'h0C;
      3'd5:                   return 8'h01;
      3'd6:                   return 8'h06;
      default:                return 8'h00;
    endcase
  endfunction

  function automatic logic [TW-1:0] rom_wait(input logic [2:0] idx);
    case (idx)
      3'd0:       return LD_GAP;
      3'd1, 3'd5: return LD_LONG;
      default:    return LD_EXEC;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    init_idx_q, init_idx_d;
  logic          init_done_q, init_done_d;
  logic          en_q, en_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          timer_done;
  logic          is_long;

  assign timer_done = (timer_q == '0);

  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  assign is_long = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PWR_WAIT;
      timer_q     <= LD_POWERUP;
      init_idx_q  <= 3'd0;
      init_done_q <= 1'b0;
      en_q        <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      en_q        <= en_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      PWR_WAIT:  if (timer_done) state_d = SETUP;
      SETUP:     if (timer_done) state_d = EN_HIGH;
      EN_HIGH:   if (timer_done) state_d = HOLD;
      HOLD:      if (timer_done) state_d = EXEC_WAIT;
      EXEC_WAIT: begin
        if (timer_done) begin
          if (init_done_q || init_idx_q == INIT_LAST) state_d = IDLE;
          else                                        state_d = SETUP;
        end
      end
      IDLE:      if (cmd.cmd_valid) state_d = SETUP;
      default:   state_d = PWR_WAIT;
    endcase
  end

  // Output / datapath next values. Outputs are computed from the next state
  // so that lcd_en and the bus come straight out of flops.
  always_comb begin
    timer_d     = (timer_q != '0) ? (timer_q - TW'(1)) : timer_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    rs_d        = rs_q;
    data_d      = data_q;
    en_d        = (state_d == EN_HIGH);

    if (state_d != state_q) begin
      case (state_d)
        SETUP:     timer_d = LD_SETUP;
        EN_HIGH:   timer_d = LD_HIGH;
        HOLD:      timer_d = LD_HOLD;
        EXEC_WAIT: timer_d = init_done_q ? (is_long ? LD_LONG : LD_EXEC)
                                         : rom_wait(init_idx_q);
        IDLE:      timer_d = '0;
        default:   timer_d = timer_q;
      endcase
    end

    // A new byte is latched onto the bus on every entry into SETUP.
    if (state_d == SETUP && state_q != SETUP) begin
      case (state_q)
        IDLE: begin
          rs_d   = cmd.cmd_rs;
          data_d = cmd.cmd_data;
        end
        EXEC_WAIT: begin
          init_idx_d = init_idx_q + 3'd1;
          rs_d       = 1'b0;
          data_d     = rom_byte(init_idx_q + 3'd1);
        end
        default: begin
          rs_d   = 1'b0;
          data_d = rom_byte(init_idx_q);
        end
      endcase
    end

    if (state_q == EXEC_WAIT && state_d == IDLE) init_done_d = 1'b1;
  end

  assign cmd.cmd_ready = (state_q == IDLE);
  assign init_done     = init_done_q;
  assign lcd_en        = en_q;
  assign lcd_rs        = rs_q;
  assign lcd_data      = data_q;
  assign lcd_rw        = 1'b0;

endmodule
